// File: rtl/piso_if.sv
// piso_if: parallel word in, serial bit out, busy/done flags.
// master = word source, slave = shift register.
interface piso_if #(
  parameter int SIZE = 8
);
  logic [SIZE-1:0] data_in;
  logic            load_in;
  logic            r_out;
  logic            busy_out;
  logic            done_out;

  modport master (
    output data_in,
    output load_in,
    input  r_out,
    input  busy_out,
    input  done_out
  );

  modport slave (
    input  data_in,
    input  load_in,
    output r_out,
    output busy_out,
    output done_out
  );
endinterface

// File: rtl/piso.sv
// piso: SIZE-bit parallel-in/serial-out shifter, MSB first by default.
// Define PISO_LSB_FIRST_EN to shift words out LSB first.
module piso #(
  parameter int SIZE = 8
) (
  input  logic   clk_in,
  input  logic   reset_in,
  piso_if.slave  bus
);
  localparam int CW = $clog2(SIZE) + 1;

  logic [SIZE-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            r_q, r_d;
  logic            load_ok;
  logic [SIZE-1:0] din;

  assign din = bus.data_in;

  // A reload is allowed on the cycle the last bit is on the wire,
  // which gives gap-free back-to-back words.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    load_ok = bus.load_in && (!busy_q || cnt_q == '0);
    if (load_ok) begin
      done_d = busy_q;
`ifdef PISO_LSB_FIRST_EN
      r_d    = din[0];
      sr_d   = din >> 1;
`else
      r_d    = din[SIZE-1];
      sr_d   = din << 1;
`endif
      cnt_d  = CW'(SIZE - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
`ifdef PISO_LSB_FIRST_EN
        r_d  = sr_q[0];
        sr_d = sr_q >> 1;
`else
        r_d  = sr_q[SIZE-1];
        sr_d = sr_q << 1;
`endif
        cnt_d = cnt_q - CW'(1);
      end else begin
        busy_d = 1'b0;
        r_d    = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers; reset wins over any load on the same edge.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      r_q    <= r_d;
    end
  end

  assign bus.r_out    = r_q;
  assign bus.busy_out = busy_q;
  assign bus.done_out = done_q;
endmodule

// File: tb/tb_piso.sv
// tb_piso: directed vectors for piso, queue-based scoreboard.
// Each driven cycle queues the expected {r,busy,done} after the edge.
module tb_piso;
  logic clk;
  logic rst;

  piso_if #(.SIZE(8)) bus ();

  piso #(.SIZE(8)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  typedef struct {
    logic [2:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stim_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit presented after edge Ek of word w.
  function automatic logic obit(input logic [7:0] w, input int k);
`ifdef PISO_LSB_FIRST_EN
    return w[k];
`else
    return w[7-k];
`endif
  endfunction

  // Drive inputs for the next edge and queue what must follow it.
  task automatic step(input logic r, input logic ld,
                      input logic [7:0] d, input logic er,
                      input logic eb, input logic ed,
                      input string nm);
    @(negedge clk);
    rst         = r;
    bus.load_in = ld;
    bus.data_in = d;
    q.push_back('{exp: {er, eb, ed}, name: nm});
  endtask

  // Shift a whole word; optional ignored load at edge ign_k.
  task automatic word(input logic [7:0] w, input bit b2b,
                      input int ign_k, input string nm);
    step(0, 1, w, obit(w, 0), 1, b2b, nm);
    for (int k = 1; k < 8; k++) begin
      if (k == ign_k)
        step(0, 1, 8'h00, obit(w, k), 1, 0, nm);
      else
        step(0, 0, ~w, obit(w, k), 1, 0, nm);
    end
  endtask

  // Monitor: compares DUT outputs after every edge against the queue.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      exp_t e;
      logic [2:0] act;
      e   = q.pop_front();
      act = {bus.r_out, bus.busy_out, bus.done_out};
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: {r,busy,done} got %b expected %b at %0t",
                 e.name, act, e.exp, $time);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.load_in = 1'b0;
    bus.data_in = 8'h00;

    // Reset dominates a held load of 8'hFF.
    for (int i = 0; i < 30; i++)
      step(1, 1, 8'hFF, 0, 0, 0, "reset");
    step(0, 0, 8'h00, 0, 0, 0, "idle");
    step(0, 0, 8'h5A, 0, 0, 0, "idle");

    // Single word 10101100: bits 1,0,1,0,1,1,0,0 then done.
    word(8'b10101100, 0, -1, "single");
    step(0, 0, 8'h00, 0, 0, 1, "single_done");
    step(0, 0, 8'h00, 0, 0, 0, "single_idle");
    step(0, 0, 8'h00, 0, 0, 0, "single_idle");

    // Back-to-back A5 then 3C: 16 contiguous bits, busy held.
    word(8'hA5, 0, -1, "b2b_a5");
    word(8'h3C, 1, -1, "b2b_3c");
    step(0, 0, 8'h00, 0, 0, 1, "b2b_done");
    step(0, 0, 8'h00, 0, 0, 0, "b2b_idle");

    // Load of 8'h00 at E3 of 8'hFF is ignored.
    word(8'hFF, 0, 3, "ignored");
    step(0, 0, 8'h00, 0, 0, 1, "ignored_done");
    step(0, 0, 8'h00, 0, 0, 0, "ignored_idle");

    // Reset at E4 of 8'hC3: bits 1,1,0,0 then discarded.
    step(0, 1, 8'hC3, obit(8'hC3, 0), 1, 0, "midrst");
    for (int k = 1; k < 4; k++)
      step(0, 0, 8'h00, obit(8'hC3, k), 1, 0, "midrst");
    step(1, 1, 8'hFF, 0, 0, 0, "midrst_rst");
    step(0, 0, 8'h00, 0, 0, 0, "midrst_nodone");
    step(0, 0, 8'h00, 0, 0, 0, "midrst_nodone");

    // Next load after reset works normally.
    word(8'b10101100, 0, -1, "after_rst");
    step(0, 0, 8'h00, 0, 0, 1, "after_rst_done");
    step(0, 0, 8'h00, 0, 0, 0, "after_rst_idle");

    stim_done = 1;
  end

  // Drain the scoreboard within a bounded number of cycles.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: stimulus not finished, expected finish");
    $fatal(1, "timeout");
  end
endmodule
